data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised word-addressed data memory for the 16-bit datapath. Successor to the
//  fixed 16x16 DataMem: valid/ready request port, byte-lane write enables, configurable
//  registered read latency, out-of-range address error, hardware zero-fill after reset.
//  Sits between the MEM stage and the data array; one request per cycle, in-order responses.
// PARAMETERS
//  DATA_W   16  data width in bits; multiple of BYTE_W
//  ADDR_W   16  request address width (word address)
//  DEPTH    16  number of words; power of two, 2..65536, DEPTH <= 2**ADDR_W
//  BYTE_W    8  bits per write-enable lane; NBE = DATA_W/BYTE_W
//  RD_LAT    1  request-accept to response latency in cycles, legal range 1..3
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  clr_start  in   1        pulse: start zero-fill sweep (ignored while sweep running)
//  req_valid  in   1        request present
//  req_ready  out  1        request accepted when req_valid & req_ready
//  req_we     in   1        1 = write, 0 = read
//  req_be     in   NBE      byte-lane enables for writes; ignored for reads
//  req_addr   in   ADDR_W   word address
//  req_wdata  in   DATA_W   write data
//  rsp_valid  out  1        one-cycle pulse per accepted request, RD_LAT cycles later
//  rsp_rdata  out  DATA_W   read data; 0 for writes and errored requests
//  rsp_err    out  1        valid with rsp_valid: address >= DEPTH
//  busy       out  1        zero-fill sweep in progress
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=1, FSM=CLEAR, clr_ptr=0.
//  - FSM: CLEAR -> RUN when clr_ptr==DEPTH-1 (that word written 0 on same edge);
//    RUN -> CLEAR on clr_start. CLEAR writes 0 to mem[clr_ptr] each cycle, clr_ptr++.
//    Sweep takes exactly DEPTH cycles; busy=1 and req_ready=0 throughout; req_ready=1 in RUN.
//  - clr_start in same cycle as an accepted request: request is accepted and completes
//    normally (response still issued); sweep starts next cycle.
//  - Index = req_addr[log2(DEPTH)-1:0]; err = (req_addr >= DEPTH). Errored write: no array
//    update. Errored read: rdata 0. Both return rsp_err=1.
//  - Write: on accept edge, lane i of mem[idx] <= req_wdata lane i where req_be[i]=1; others kept.
//    req_be all-zero: no change, response still issued.
//  - Read: array sampled on accept edge; read of the word written in previous cycle returns
//    new data. Only one request per cycle, so no same-cycle collision exists.
//  - Response pipe: RD_LAT-stage shift of {valid, err, rdata}; request accepted at edge N
//    gives rsp_valid high in cycle after edge N+RD_LAT-1. Fully pipelined: back-to-back
//    accepts give back-to-back responses, strict request order. No response backpressure.
//  - Response pipe keeps draining during CLEAR; in-flight reads carry pre-clear data.
//  - rst_n assertion mid-sweep or mid-pipeline: pipe flushed (no responses), sweep restarts
//    at 0 after release. Array contents not reset by rst_n; only by sweep.
//  - Widths: clr_ptr is log2(DEPTH) bits; compare to DEPTH done at ADDR_W+1 bits (no wrap).
// STRUCTURE
//  - Package data_mem_pkg: FSM state enum {CLEAR, RUN}, RD_LAT_MIN=1/RD_LAT_MAX=3,
//    rsp struct {valid, err, rdata}; elaboration check rejects illegal parameters.
//  - One sub-module: data_mem_rsp_pipe (parametrised RD_LAT shift register, async reset
//    of valid bits). Array, byte merge and FSM live in data_mem_ctrl.
// TESTING (defaults unless stated)
//  1 Reset release -> busy=1, req_ready=0 for 16 cycles, then req_ready=1; read all
//    addrs 0..15 -> rdata 0x0000, err=0.
//  2 Write 0xBEEF @3 be=11; write 0x1200 @3 be=10; read @3 -> rsp 0x12EF, one cycle after
//    accept (RD_LAT=1); RD_LAT=3 run: same data three cycles after accept.
//  3 Back-to-back: write 0xA5A5 @7 then read @7 next cycle -> 0xA5A5; 8 alternating
//    accepts -> 8 consecutive rsp_valid pulses in order.
//  4 Write 0x1111 @16 and read @0xFFFF -> both rsp_err=1, rdata 0; mem[0] unchanged.
//  5 Fill mem, pulse clr_start with read @5 accepted same cycle -> read returns old data,
//    then 16 busy cycles, all words 0 after.
//  6 rst_n low for 1 cycle mid-sweep and with 2 reads in flight -> no rsp_valid, sweep
//    restarts, full 16-cycle busy after release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state, read-latency limits and parameter legality check for data_mem_ctrl
package data_mem_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  typedef struct packed {
    logic valid;
    logic err;
  } rsp_flags_t;
  function automatic bit params_ok(int data_w, int addr_w, int depth, int byte_w, int rd_lat);
    return byte_w > 0 && data_w > 0 && (data_w % byte_w) == 0 &&
           depth >= 2 && depth <= 65536 && (depth & (depth - 1)) == 0 &&
           longint'(depth) <= (longint'(1) << addr_w) &&
           rd_lat >= RD_LAT_MIN && rd_lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus of the data memory
// master drives req_valid/we/be/addr/wdata and receives req_ready and rsp_valid/err/rdata;
// slave is the memory side
interface data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int BYTE_W = 8
);
  localparam int NBE = DATA_W / BYTE_W;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NBE-1:0]    req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/data_mem_rsp_pipe.sv
// data_mem_rsp_pipe: RD_LAT-stage response shift register, cleared by async reset
// Ports: clk, rst_n (async active-low), i_d (response word entering), o_q (response word leaving)
module data_mem_rsp_pipe #(
  parameter int W      = 18,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_pipe [RD_LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  assign o_q = r_pipe[RD_LAT-1];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed data memory with byte-lane writes, pipelined reads, range error and zero-fill sweep
// Ports: clk, rst_n (async active-low), clr_start (pulse: start zero-fill), busy (sweep running),
//        bus (slave side of data_mem_if: valid/ready request, in-order responses)
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr_start,
  output logic      busy,
  data_mem_if.slave bus
);
  localparam int NBE = DATA_W / BYTE_W;
  localparam int IDX_W = $clog2(DEPTH);
  // Range compare is one bit wider than the address so DEPTH == 2**ADDR_W does not wrap
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  typedef struct packed {
    rsp_flags_t        f;
    logic [DATA_W-1:0] rdata;
  } rsp_t;
  if (!params_ok(DATA_W, ADDR_W, DEPTH, BYTE_W, RD_LAT)) begin : g_bad_params
    $error("data_mem_ctrl: illegal parameter combination");
  end
  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_acc, w_err, w_wr, w_rd;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_merge;
  rsp_t              w_rsp_in, w_rsp_out;
  assign busy          = r_state == CLEAR;
  assign bus.req_ready = r_state == RUN;
  assign w_acc = bus.req_valid & bus.req_ready;
  assign w_err = {1'b0, bus.req_addr} >= DEPTH_X;
  assign w_idx = bus.req_addr[IDX_W-1:0];
  assign w_wr  = w_acc & bus.req_we & ~w_err;
  assign w_rd  = w_acc & ~bus.req_we & ~w_err;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == CLEAR) ? ((r_clr_ptr == IDX_W'(DEPTH - 1)) ? RUN : CLEAR)
                                : (clr_start ? CLEAR : RUN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_next;
      r_clr_ptr <= busy ? r_clr_ptr + IDX_W'(1) : '0;
    end
  always_comb begin
    w_merge = r_mem[w_idx];
    for (int i = 0; i < NBE; i++)
      if (bus.req_be[i]) w_merge[i*BYTE_W +: BYTE_W] = bus.req_wdata[i*BYTE_W +: BYTE_W];
  end
  // The array has no reset: only the sweep clears it
  always_ff @(posedge clk)
    if (busy) r_mem[r_clr_ptr] <= '0;
    else if (w_wr) r_mem[w_idx] <= w_merge;
  always_comb begin
    w_rsp_in         = '0;
    w_rsp_in.f.valid = w_acc;
    w_rsp_in.f.err   = w_acc & w_err;
    w_rsp_in.rdata   = w_rd ? r_mem[w_idx] : '0;
  end
  data_mem_rsp_pipe #(.W($bits(rsp_t)), .RD_LAT(RD_LAT)) u_rsp_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (w_rsp_in),
    .o_q  (w_rsp_out)
  );
  assign bus.rsp_valid = w_rsp_out.f.valid;
  assign bus.rsp_err   = w_rsp_out.f.err;
  assign bus.rsp_rdata = w_rsp_out.rdata;
endmodule
